// File: rtl/add_arbiter.sv
// add_arbiter
//   Two requesters (0 = execute, 1 = address generation) share one WIDTH-bit
//   adder. A winner is picked each cycle and its result is registered into a
//   single response slot together with its signed-overflow, zero and sign
//   flags. There is one cycle of latency. When both requesters are valid, the
//   grant alternates via a priority pointer.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   reqN_valid/ready               request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_sub       signed operands; sub=1 selects a-b
//   rsp_valid/ready                response handshake
//   rsp_id                         owner of the held result
//   rsp_sum                        result modulo 2^WIDTH
//   rsp_of, rsp_zf, rsp_sf         signed overflow / zero / sign of rsp_sum
module add_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_of,
  output logic             rsp_zf,
  output logic             rsp_sf
);

  logic             r_ptr;
  logic             r_valid;
  logic             r_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_of;
  logic             r_zf;
  logic             r_sf;

  logic             w_free;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_xfer0;
  logic             w_xfer1;
  logic             w_xfer;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_sub;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_of;

  // The slot can take a new result if it is empty or being drained now.
  assign w_free = !r_valid || rsp_ready;

  // Grant uses only the valids and the pointer, never the operands.
  assign w_gnt0 = req0_valid && (!req1_valid || !r_ptr);
  assign w_gnt1 = req1_valid && (!req0_valid ||  r_ptr);

  // The rst_n gate keeps both readys low while reset is held.
  assign w_xfer0 = rst_n && w_free && w_gnt0;
  assign w_xfer1 = rst_n && w_free && w_gnt1;
  assign w_xfer  = w_xfer0 || w_xfer1;

  assign req0_ready = w_xfer0;
  assign req1_ready = w_xfer1;

  // Operand mux in front of the single shared adder.
  assign w_a   = w_gnt1 ? req1_a   : req0_a;
  assign w_b   = w_gnt1 ? req1_b   : req0_b;
  assign w_sub = w_gnt1 ? req1_sub : req0_sub;

  // Subtract is a + ~b + 1; the +1 enters as the carry-in of the same adder.
  // The carry-out is dropped because the sum is only WIDTH bits wide.
  assign w_op_b = w_sub ? ~w_b : w_b;
  assign w_sum  = w_a + w_op_b + {{(WIDTH-1){1'b0}}, w_sub};

  always_comb begin
    w_of = 1'b0;
    if (w_sub)
      w_of = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
    else
      w_of = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= 1'b0;
      r_valid <= 1'b0;
      r_id    <= 1'b0;
      r_sum   <= '0;
      r_of    <= 1'b0;
      r_zf    <= 1'b0;
      r_sf    <= 1'b0;
    end else begin
      if (w_xfer) begin
        // Next priority goes to the requester that was not served.
        r_ptr   <= !w_xfer1;
        r_valid <= 1'b1;
        r_id    <= w_xfer1;
        r_sum   <= w_sum;
        r_of    <= w_of;
        r_zf    <= (w_sum == '0);
        r_sf    <= w_sum[WIDTH-1];
      end else if (rsp_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_of    = r_of;
  assign rsp_zf    = r_zf;
  assign rsp_sf    = r_sf;

endmodule
